// File: rtl/ul_arb4_rr_wr.sv
// ul_arb4_rr_wr: four-requester round-robin write arbiter
// feeding a single held output slot with stall-timeout drop.
module ul_arb4_rr_wr #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  s_ul_clk,
    input  logic                  s_ul_rst,
    input  logic [ADDR_WIDTH-1:0] s0_ul_waddr,
    input  logic [DATA_WIDTH-1:0] s0_ul_wdata,
    input  logic                  s0_ul_wvalid,
    output logic                  s0_ul_wready,
    input  logic [ADDR_WIDTH-1:0] s1_ul_waddr,
    input  logic [DATA_WIDTH-1:0] s1_ul_wdata,
    input  logic                  s1_ul_wvalid,
    output logic                  s1_ul_wready,
    input  logic [ADDR_WIDTH-1:0] s2_ul_waddr,
    input  logic [DATA_WIDTH-1:0] s2_ul_wdata,
    input  logic                  s2_ul_wvalid,
    output logic                  s2_ul_wready,
    input  logic [ADDR_WIDTH-1:0] s3_ul_waddr,
    input  logic [DATA_WIDTH-1:0] s3_ul_wdata,
    input  logic                  s3_ul_wvalid,
    output logic                  s3_ul_wready,
    output logic [ADDR_WIDTH-1:0] m_ul_waddr,
    output logic [DATA_WIDTH-1:0] m_ul_wdata,
    output logic                  m_ul_wvalid,
    input  logic                  m_ul_wready,
    output logic [1:0]            m_ul_wsrc,
    output logic                  drop_pulse,
    output logic [7:0]            drop_cnt
);

    logic [ADDR_WIDTH-1:0] addr_arr [4];
    logic [DATA_WIDTH-1:0] data_arr [4];
    logic [3:0]            req;
    logic [3:0]            wready;
    logic [1:0]            last_grant;
    logic [7:0]            wait_cnt;
    logic [1:0]            gnt_idx;
    logic                  gnt_found;
    logic                  drop_fire;
    logic                  slot_free;
    logic                  accept;

    assign addr_arr[0] = s0_ul_waddr;
    assign addr_arr[1] = s1_ul_waddr;
    assign addr_arr[2] = s2_ul_waddr;
    assign addr_arr[3] = s3_ul_waddr;
    assign data_arr[0] = s0_ul_wdata;
    assign data_arr[1] = s1_ul_wdata;
    assign data_arr[2] = s2_ul_wdata;
    assign data_arr[3] = s3_ul_wdata;
    assign req = {s3_ul_wvalid, s2_ul_wvalid, s1_ul_wvalid, s0_ul_wvalid};

    assign drop_fire = (WAIT_LIMIT != 0) && m_ul_wvalid && !m_ul_wready
                       && (wait_cnt == 8'(WAIT_LIMIT));
    assign slot_free = !m_ul_wvalid || m_ul_wready || drop_fire;

    // Round-robin search starting just past the last granted requester.
    always_comb begin
        logic [1:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = 2'd0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = last_grant + 2'(i + 1);
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    // Ready goes only to the winner, and only when the slot can take a beat.
    always_comb begin
        wready = 4'b0000;
        if (gnt_found && slot_free && !s_ul_rst)
            wready[gnt_idx] = 1'b1;
    end

    assign accept       = |(wready & req);
    assign s0_ul_wready = wready[0];
    assign s1_ul_wready = wready[1];
    assign s2_ul_wready = wready[2];
    assign s3_ul_wready = wready[3];

    // Output slot, priority pointer, stall timer and drop accounting.
    always_ff @(posedge s_ul_clk) begin
        if (s_ul_rst) begin
            m_ul_wvalid <= 1'b0;
            m_ul_wsrc   <= 2'd0;
            m_ul_waddr  <= '0;
            m_ul_wdata  <= '0;
            drop_pulse  <= 1'b0;
            drop_cnt    <= 8'd0;
            wait_cnt    <= 8'd0;
            last_grant  <= 2'd3;
        end else begin
            drop_pulse <= drop_fire;
            if (drop_fire && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
            if (accept) begin
                m_ul_wvalid <= 1'b1;
                m_ul_waddr  <= addr_arr[gnt_idx];
                m_ul_wdata  <= data_arr[gnt_idx];
                m_ul_wsrc   <= gnt_idx;
                last_grant  <= gnt_idx;
                wait_cnt    <= 8'd0;
            end else if ((m_ul_wvalid && m_ul_wready) || drop_fire) begin
                m_ul_wvalid <= 1'b0;
                wait_cnt    <= 8'd0;
            end else if (m_ul_wvalid && !m_ul_wready
                         && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

endmodule
